// File: rtl/max_kbd_pkg.sv
// Shared types and constants for the MAX keyboard path: PS/2 deframer states,
// key matrix positions and the set-2 prefix/control bytes.
package max_kbd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } kbd_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    localparam logic [7:0] PS2_EXT     = 8'hE0;
    localparam logic [7:0] PS2_REL     = 8'hF0;
    localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
    localparam logic [7:0] PS2_BAT_ERR = 8'hFC;

    function automatic key_pos_t kp(input logic [2:0] r, input logic [2:0] c);
        key_pos_t p;
        p.valid = 1'b1;
        p.row   = r;
        p.col   = c;
        return p;
    endfunction

    // Bytes that mean the keyboard restarted or overran: forget every held key.
    function automatic logic is_kbd_reset(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_BAT_ERR) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_c64_keymap.sv
// Set-2 scancode (plus E0 flag) to C64/MAX matrix position; row = PB bit, col = PA bit.
module ps2_c64_keymap
    import max_kbd_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output key_pos_t   pos
);

    always_comb begin
        pos = '0;
        case ({ext, code})
            // column 0: DEL RETURN CRSR-RT F7 F1 F3 F5 CRSR-DN
            9'h066: pos = kp(3'd0, 3'd0);
            9'h171: pos = kp(3'd0, 3'd0);
            9'h05A: pos = kp(3'd1, 3'd0);
            9'h174: pos = kp(3'd2, 3'd0);
            9'h083: pos = kp(3'd3, 3'd0);
            9'h005: pos = kp(3'd4, 3'd0);
            9'h004: pos = kp(3'd5, 3'd0);
            9'h003: pos = kp(3'd6, 3'd0);
            9'h172: pos = kp(3'd7, 3'd0);
            9'h026: pos = kp(3'd0, 3'd1);
            9'h01D: pos = kp(3'd1, 3'd1);
            9'h01C: pos = kp(3'd2, 3'd1);
            9'h025: pos = kp(3'd3, 3'd1);
            9'h01A: pos = kp(3'd4, 3'd1);
            9'h01B: pos = kp(3'd5, 3'd1);
            9'h024: pos = kp(3'd6, 3'd1);
            9'h012: pos = kp(3'd7, 3'd1);
            9'h02E: pos = kp(3'd0, 3'd2);
            9'h02D: pos = kp(3'd1, 3'd2);
            9'h023: pos = kp(3'd2, 3'd2);
            9'h036: pos = kp(3'd3, 3'd2);
            9'h021: pos = kp(3'd4, 3'd2);
            9'h02B: pos = kp(3'd5, 3'd2);
            9'h02C: pos = kp(3'd6, 3'd2);
            9'h022: pos = kp(3'd7, 3'd2);
            9'h03D: pos = kp(3'd0, 3'd3);
            9'h035: pos = kp(3'd1, 3'd3);
            9'h034: pos = kp(3'd2, 3'd3);
            9'h03E: pos = kp(3'd3, 3'd3);
            9'h032: pos = kp(3'd4, 3'd3);
            9'h033: pos = kp(3'd5, 3'd3);
            9'h03C: pos = kp(3'd6, 3'd3);
            9'h02A: pos = kp(3'd7, 3'd3);
            9'h046: pos = kp(3'd0, 3'd4);
            9'h043: pos = kp(3'd1, 3'd4);
            9'h03B: pos = kp(3'd2, 3'd4);
            9'h045: pos = kp(3'd3, 3'd4);
            9'h03A: pos = kp(3'd4, 3'd4);
            9'h042: pos = kp(3'd5, 3'd4);
            9'h044: pos = kp(3'd6, 3'd4);
            9'h031: pos = kp(3'd7, 3'd4);
            // column 5/6 punctuation follows the PC key caps closest to the C64 legend
            9'h04E: pos = kp(3'd0, 3'd5);
            9'h04D: pos = kp(3'd1, 3'd5);
            9'h04B: pos = kp(3'd2, 3'd5);
            9'h055: pos = kp(3'd3, 3'd5);
            9'h049: pos = kp(3'd4, 3'd5);
            9'h04C: pos = kp(3'd5, 3'd5);
            9'h054: pos = kp(3'd6, 3'd5);
            9'h041: pos = kp(3'd7, 3'd5);
            9'h05D: pos = kp(3'd0, 3'd6);
            9'h05B: pos = kp(3'd1, 3'd6);
            9'h052: pos = kp(3'd2, 3'd6);
            9'h16C: pos = kp(3'd3, 3'd6);
            9'h059: pos = kp(3'd4, 3'd6);
            9'h04A: pos = kp(3'd7, 3'd6);
            9'h016: pos = kp(3'd0, 3'd7);
            9'h00E: pos = kp(3'd1, 3'd7);
            9'h014: pos = kp(3'd2, 3'd7);
            9'h114: pos = kp(3'd2, 3'd7);
            9'h01E: pos = kp(3'd3, 3'd7);
            9'h029: pos = kp(3'd4, 3'd7);
            9'h11F: pos = kp(3'd5, 3'd7);
            9'h015: pos = kp(3'd6, 3'd7);
            9'h076: pos = kp(3'd7, 3'd7);
            default: pos = '0;
        endcase
    end

endmodule

// File: rtl/ps2_kbd_matrix.sv
// PS/2 keyboard receiver: deframes set-2 bytes, tracks held keys in an 8x8 C64
// matrix and answers CIA port scans the way the physical keyboard would.
//
//   state | meaning
//   IDLE  | waiting for a falling edge carrying a start bit (data = 0)
//   SHIFT | collecting 8 data bits, parity and stop on successive falling edges
//   CHECK | one cycle: validate parity/stop, hand the byte to the decoder
module ps2_kbd_matrix
    import max_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] pa_o,
    input  logic [7:0] pb_o,
    output logic [7:0] pa_i,
    output logic [7:0] pb_i,
    output logic       key_strobe,
    output logic [7:0] key_code,
    output logic       key_release,
    output logic       frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   ps2_fall;
    logic                   ps2_bit;

    kbd_state_t      state, state_nxt;
    logic [3:0]      bit_cnt;
    logic [9:0]      shreg;
    logic [TO_W-1:0] to_cnt;
    logic            timeout;
    logic            byte_valid;
    logic            err_c;

    logic            ext, rel;
    logic [7:0]      rx_byte;
    key_pos_t        pos;
    logic [7:0][7:0] matrix;
    logic [7:0]      pa_scan, pb_scan;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync[0]  <= ps2_clk;
            data_sync[0] <= ps2_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync[i]  <= clk_sync[i-1];
                data_sync[i] <= data_sync[i-1];
            end
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign ps2_fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign ps2_bit  = data_sync[SYNC_STAGES-1];
    assign timeout  = (to_cnt == TO_W'(TIMEOUT_CYCLES));
    assign rx_byte  = shreg[7:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        byte_valid = 1'b0;
        err_c      = 1'b0;
        case (state)
            IDLE: begin
                if (ps2_fall && !ps2_bit) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (ps2_fall) begin
                    if (bit_cnt == 4'd9) state_nxt = CHECK;
                end else if (timeout) begin
                    err_c     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
                if ((^shreg[8:0]) && shreg[9]) byte_valid = 1'b1;
                else                           err_c      = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame bits arrive LSB first; after ten shifts stop sits in [9], parity in [8].
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            to_cnt    <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_c;
            if (ps2_fall)
                to_cnt <= '0;
            else if (state == SHIFT && !timeout)
                to_cnt <= to_cnt + 1'b1;
            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (state == SHIFT && ps2_fall) begin
                shreg   <= {ps2_bit, shreg[9:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    ps2_c64_keymap u_keymap (
        .ext  (ext),
        .code (rx_byte),
        .pos  (pos)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext         <= 1'b0;
            rel         <= 1'b0;
            matrix      <= '0;
            key_strobe  <= 1'b0;
            key_code    <= '0;
            key_release <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (byte_valid) begin
                if (rx_byte == PS2_EXT) begin
                    ext <= 1'b1;
                end else if (rx_byte == PS2_REL) begin
                    rel <= 1'b1;
                end else if (is_kbd_reset(rx_byte)) begin
                    matrix <= '0;
                    ext    <= 1'b0;
                    rel    <= 1'b0;
                end else begin
                    ext <= 1'b0;
                    rel <= 1'b0;
                    if (pos.valid) begin
                        matrix[pos.row][pos.col] <= ~rel;
                        key_strobe  <= 1'b1;
                        key_code    <= rx_byte;
                        key_release <= rel;
                    end
                end
            end
        end
    end

    // A held key pulls its row low when its column is driven and vice versa.
    always_comb begin
        pa_scan = pa_o;
        pb_scan = pb_o;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (matrix[r][c] && !pa_o[c]) pb_scan[r] = 1'b0;
                if (matrix[r][c] && !pb_o[r]) pa_scan[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pa_i <= 8'hFF;
            pb_i <= 8'hFF;
        end else begin
            pa_i <= pa_scan;
            pb_i <= pb_scan;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_matrix.sv
// Directed bench for ps2_kbd_matrix: bit-bangs PS/2 frames and checks the
// scan outputs, decode flags and error pulses against hand-computed values.
module tb_ps2_kbd_matrix;

    localparam int HALF = 8;

    logic       clk;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] pa_o;
    logic [7:0] pb_o;
    logic [7:0] pa_i;
    logic [7:0] pb_i;
    logic       key_strobe;
    logic [7:0] key_code;
    logic       key_release;
    logic       frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int n_strobe = 0;
    int n_ferr = 0;

    ps2_kbd_matrix dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .pa_o        (pa_o),
        .pb_o        (pb_o),
        .pa_i        (pa_i),
        .pb_i        (pb_i),
        .key_strobe  (key_strobe),
        .key_code    (key_code),
        .key_release (key_release),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_strobe === 1'b1) n_strobe++;
        if (frame_err === 1'b1)  n_ferr++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic d);
        ps2_data = d;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ bad_par);
        ps2_bit(1'b1);
        repeat (4 * HALF) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        pa_o     = 8'hFF;
        pb_o     = 8'hFF;
        repeat (5) @(negedge clk);
        chk("rst_pa_i", pa_i, 8'hFF);
        chk("rst_pb_i", pb_i, 8'hFF);
        chk("rst_key_code", key_code, 8'h00);
        chk("rst_key_release", key_release, 1'b0);
        chk("rst_key_strobe", key_strobe, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // A press and release, column 1 driven
        pa_o = 8'hFD;
        send(8'h1C);
        chk("a_make_pb_i", pb_i, 8'hFB);
        chk("a_make_pa_i", pa_i, 8'hFD);
        chk("a_make_code", key_code, 8'h1C);
        chk("a_make_rel", key_release, 1'b0);
        chk("a_make_strobes", n_strobe, 1);
        send(8'hF0);
        send(8'h1C);
        chk("a_break_pb_i", pb_i, 8'hFF);
        chk("a_break_rel", key_release, 1'b1);
        chk("a_break_strobes", n_strobe, 2);

        // Cursor down, both extended-break prefix orders, plain 72 unmapped
        pa_o = 8'hFE;
        send(8'hE0); send(8'h72);
        chk("crsr_make_pb_i", pb_i, 8'h7F);
        send(8'hE0); send(8'hF0); send(8'h72);
        chk("crsr_e0f0_pb_i", pb_i, 8'hFF);
        chk("crsr_e0f0_rel", key_release, 1'b1);
        send(8'hE0); send(8'h72);
        chk("crsr_remake_pb_i", pb_i, 8'h7F);
        send(8'hF0); send(8'hE0); send(8'h72);
        chk("crsr_f0e0_pb_i", pb_i, 8'hFF);
        chk("crsr_strobes", n_strobe, 6);
        send(8'h72);
        chk("kp2_unmapped_pb_i", pb_i, 8'hFF);
        chk("kp2_unmapped_strobes", n_strobe, 6);

        // LShift + Space, forward and reverse scans
        send(8'h12); send(8'h29);
        pa_o = 8'h7D;
        settle();
        chk("shift_space_pb_i", pb_i, 8'h6F);
        pa_o = 8'hFF;
        pb_o = 8'h7F;
        settle();
        chk("rev_scan_pa_i", pa_i, 8'hFD);
        chk("rev_scan_pb_i", pb_i, 8'h7F);
        send(8'h12);
        chk("repeat_make_pa_i", pa_i, 8'hFD);
        chk("repeat_make_strobes", n_strobe, 9);
        send(8'hF0); send(8'h1C);
        chk("break_unheld_pa_i", pa_i, 8'hFD);
        chk("break_unheld_strobes", n_strobe, 10);
        send(8'hF0); send(8'h12);
        send(8'hF0); send(8'h29);
        chk("shift_rel_pa_i", pa_i, 8'hFF);
        pb_o = 8'hFF;

        // Return with bad parity, then good
        pa_o = 8'hFE;
        send_frame(8'h5A, 1'b1);
        chk("badpar_ferr", n_ferr, 1);
        chk("badpar_pb_i", pb_i, 8'hFF);
        chk("badpar_strobes", n_strobe, 12);
        send(8'h5A);
        chk("ret_pb_i", pb_i, 8'hFD);
        chk("ret_ferr", n_ferr, 1);
        send(8'hF0); send(8'h5A);
        chk("ret_rel_pb_i", pb_i, 8'hFF);

        // Truncated frame: timeout just before and just after the limit
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (63900) @(negedge clk);
        chk("timeout_early_ferr", n_ferr, 1);
        repeat (200) @(negedge clk);
        chk("timeout_ferr", n_ferr, 2);
        pa_o = 8'hFD;
        send(8'h1C);
        chk("post_to_pb_i", pb_i, 8'hFB);
        chk("post_to_code", key_code, 8'h1C);
        send(8'hF0); send(8'h1C);
        chk("post_to_rel_pb_i", pb_i, 8'hFF);

        // Three keys then BAT; pending F0 cleared by BAT
        send(8'h1C); send(8'h12); send(8'h29);
        pa_o = 8'h00;
        settle();
        chk("three_keys_pb_i", pb_i, 8'h6B);
        send(8'hAA);
        chk("bat_pb_i", pb_i, 8'hFF);
        chk("bat_strobes", n_strobe, 19);
        send(8'hF0); send(8'hAA); send(8'h1C);
        chk("bat_clr_rel", key_release, 1'b0);
        chk("bat_clr_pb_i", pb_i, 8'hFB);
        chk("bat_clr_strobes", n_strobe, 20);

        // Reset mid-frame
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset_n = 1'b0;
        #1;
        chk("midrst_pb_i", pb_i, 8'hFF);
        chk("midrst_pa_i", pa_i, 8'hFF);
        chk("midrst_code", key_code, 8'h00);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("midrst_after_pb_i", pb_i, 8'hFF);
        chk("midrst_after_ferr", n_ferr, 2);
        chk("midrst_after_strobes", n_strobe, 20);
        send(8'h1C);
        chk("midrst_a_pb_i", pb_i, 8'hFB);
        chk("midrst_a_code", key_code, 8'h1C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_matrix.md
Name: ps2_kbd_matrix

Overview:
- Receiving end of the PS/2 keyboard stream that the MiST I/O controller transmits (ps2_kbd_clk / ps2_kbd_data).
- Deframes the PS/2 bytes and decodes set-2 make/break/E0 sequences into an 8x8 C64/MAX key matrix.
- Presents that matrix to CIA U12 port A/port B exactly as the physical keyboard would.
- Sits in the MAX top level between mist_io and cia6526.

Parameters:
- TIMEOUT_CYCLES, 64000, clk cycles with no PS/2 falling edge mid-frame before the frame is abandoned (2 ms at 32 MHz).
- SYNC_STAGES, 2, synchroniser flops on ps2_clk and ps2_data.

Ports:
- clk  in  1  system clock (clk_cpu domain).
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  PS/2 clock from mist_io, asynchronous.
- ps2_data  in  1  PS/2 data from mist_io, asynchronous.
- pa_o  in  8  CIA port A output (column drive, active low).
- pb_o  in  8  CIA port B output (row drive, active low).
- pa_i  out  8  value fed to CIA port A input.
- pb_i  out  8  value fed to CIA port B input.
- key_strobe  out  1  one-cycle pulse per accepted make/break that hit a mapped key.
- key_code  out  8  last accepted scancode, excluding prefixes.
- key_release  out  1  break flag of last accepted code.
- frame_err  out  1  one-cycle pulse on a parity, start-bit or stop-bit error, or on a timeout.

Behaviour:
- Reset (async assert, sync deassert handled upstream) applies these values: matrix all 0, flags cleared, FSM IDLE, pa_i = pb_i = 8'hFF, key_code = 0, key_release = 0, strobes = 0.
- ps2_clk and ps2_data each pass through SYNC_STAGES flops. A falling edge means the previous synced value was 1 and the current one is 0.
- FSM IDLE: on a falling edge with data = 0 (start bit), go to SHIFT with bit count 0. If data = 1, stay in IDLE.
- FSM SHIFT: on each falling edge, shift data into bit[7:0] LSB first. Edges 1..8 capture data, edge 9 captures parity, edge 10 captures stop, then go to CHECK.
- FSM CHECK (one cycle): the byte is valid when odd parity holds over data and parity, and stop = 1. If valid, raise byte_valid. If not, pulse frame_err. Either way return to IDLE.
- Timeout: a counter clears on every falling edge and increments in SHIFT. When it reaches TIMEOUT_CYCLES, pulse frame_err and go to IDLE. The counter saturates and never wraps.
- Decode on byte_valid:
  - E0 sets ext.
  - F0 sets rel.
  - AA, FC, 00 or FF clears the whole matrix and both flags, with no strobe.
  - Any other byte goes through the keymap. If mapped, matrix[row][col] <= ~rel, key_strobe = 1, key_code = byte, key_release = rel. If unmapped, the matrix is unchanged and there is no strobe.
  - In both the mapped and unmapped cases, ext and rel clear after a non-prefix byte.
- Prefix order: E0 F0 xx and F0 E0 xx are both accepted as an extended break.
- Repeated make of a held key leaves its bit at 1. A break of a key that is not held leaves its bit at 0. key_strobe still pulses in both cases.
- Matrix indexing: row = PB bit, col = PA bit.
- Scan outputs are registered with 1 clk latency from pa_o/pb_o or a matrix change:
  - pb_i[r] = pb_o[r] & ~|(matrix[r][c] & ~pa_o[c]) over all c.
  - pa_i[c] = pa_o[c] & ~|(matrix[r][c] & ~pb_o[r]) over all r.
- A matrix update and a scan change in the same cycle: the scan uses the pre-update matrix, and the new value appears on the next cycle.
- Reset asserted mid-frame: the FSM aborts immediately and no partial byte is decoded.
- Keys with no MAX matrix position (F-keys other than F1/F3/F5/F7, numpad extras) are unmapped.

Decomposition:
- Package max_kbd_pkg holds:
  - typedef kbd_state_t {IDLE, SHIFT, CHECK};
  - typedef struct {logic valid; logic [2:0] row; logic [2:0] col;} key_pos_t;
  - constants PS2_EXT = 8'hE0, PS2_REL = 8'hF0, PS2_BAT_OK = 8'hAA, PS2_BAT_ERR = 8'hFC.
- Sub-module ps2_c64_keymap: combinational, inputs {ext, code[7:0]}, output key_pos_t. The module is a pure LUT, so the table can be verified on its own.

Test Plan:
- Frame 1C (A), good parity, then F0 1C -> matrix[2][1] = 1 then 0. With pa_o = 8'hFD: pb_i = 8'hFB while held and 8'hFF after release. key_strobe pulses twice, key_release goes 0 then 1.
- E0 72 (cursor down) with pa_o = 8'hFE -> pb_i = 8'h7F. Then E0 F0 72 -> pb_i = 8'hFF.
- Hold 12 (LShift, row7 col1) and 29 (Space, row4 col7), pa_o = 8'h7D -> pb_i = 8'h6F. Reverse scan with pb_o = 8'h7F, pa_o = 8'hFF -> pa_i = 8'hFD.
- Byte 5A (Return) with wrong parity -> frame_err pulse, matrix unchanged. Send the same frame with correct parity -> matrix[1][0] = 1.
- Start bit plus 4 data edges, then silence for 64000 clks -> frame_err pulse and FSM back in IDLE. A following full 1C frame decodes correctly.
- Three keys held, then byte AA -> matrix all 0, pb_i = 8'hFF for pa_o = 8'h00. Assert reset_n = 0 mid-frame -> outputs at reset values immediately.
